// File: rtl/fifo2_rr_enq_arbiter_if.sv
// Enqueue-side bundle between NREQ producers, the round-robin arbiter and a FIFO2.
// The arbiter takes the slave view; producers and the FIFO model take the master view.
interface fifo2_rr_enq_arbiter_if #(
   parameter int WIDTH = 1,
   parameter int NREQ  = 4,
   parameter int TAGW  = 2
);
   logic [NREQ-1:0]       REQ_V;
   logic [NREQ*WIDTH-1:0] REQ_D;
   logic [NREQ-1:0]       REQ_LAST;
   logic [NREQ-1:0]       REQ_ACK;
   logic                  F_FULL_N;
   logic                  F_ENQ;
   logic [TAGW+WIDTH-1:0] F_D;
   logic                  BUSY;

   modport slave (
      input  REQ_V, REQ_D, REQ_LAST, F_FULL_N,
      output REQ_ACK, F_ENQ, F_D, BUSY
   );

   modport master (
      output REQ_V, REQ_D, REQ_LAST, F_FULL_N,
      input  REQ_ACK, F_ENQ, F_D, BUSY
   );
endinterface

// File: rtl/fifo2_rr_enq_arbiter.sv
// Round-robin arbiter sharing the enqueue port of one FIFO2 among NREQ producers; F_D = {tag, payload}.
// Define FIFO2_ARB_LOCK_EN to hold the grant on one requester until its REQ_LAST beat (packet lock).
module fifo2_rr_enq_arbiter #(
   parameter int WIDTH = 1,
   parameter int NREQ  = 4,
   parameter int TAGW  = 2
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        CLR,
   fifo2_rr_enq_arbiter_if.slave       bus
);

   logic [TAGW-1:0]  ptr_q;
   logic [TAGW-1:0]  ptr_d;
   logic             clear;
   logic             rr_found;
   logic [TAGW-1:0]  rr_idx;
   logic             grant_found;
   logic [TAGW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             grant_last;
   logic             accept;
   logic [NREQ-1:0]  req_ack;
   logic [TAGW-1:0]  grant_wrap;

   assign clear = RST | CLR;

`ifdef FIFO2_ARB_LOCK_EN
   logic             lock_q;
   logic             lock_d;
   logic [TAGW-1:0]  lk_idx_q;
   logic [TAGW-1:0]  lk_idx_d;
   logic             lk_valid;
   logic [TAGW-1:0]  lk_wrap;
`endif

   // Round-robin search: lowest valid index at or above ptr, else lowest valid index overall.
   always_comb begin
      logic            hi_found;
      logic            lo_found;
      logic [TAGW-1:0] hi_idx;
      logic [TAGW-1:0] lo_idx;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.REQ_V[i] && !hi_found && (i >= int'(ptr_q))) begin
            hi_found = 1'b1;
            hi_idx   = TAGW'(i);
         end
         if (bus.REQ_V[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = TAGW'(i);
         end
      end
      rr_found = hi_found | lo_found;
      rr_idx   = hi_found ? hi_idx : lo_idx;
   end

`ifdef FIFO2_ARB_LOCK_EN
   // While locked only the owning requester is eligible, even when it is idle.
   always_comb begin
      lk_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (TAGW'(i) == lk_idx_q) begin
            lk_valid = bus.REQ_V[i];
         end
      end
      if (lock_q) begin
         grant_found = lk_valid;
         grant_idx   = lk_idx_q;
      end else begin
         grant_found = rr_found;
         grant_idx   = rr_idx;
      end
   end
`else
   always_comb begin
      grant_found = rr_found;
      grant_idx   = rr_idx;
   end
`endif

   always_comb begin
      grant_data = '0;
      grant_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (TAGW'(i) == grant_idx) begin
            grant_data = bus.REQ_D[i*WIDTH +: WIDTH];
            grant_last = bus.REQ_LAST[i];
         end
      end
   end

   // Reset and soft clear suppress the handshake for the whole cycle they are asserted.
   assign accept = grant_found & bus.F_FULL_N & ~clear;

   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ack[i] = accept && (TAGW'(i) == grant_idx);
      end
   end

   // Wrap modulo NREQ, not modulo 2^TAGW, so no out-of-range tag is ever produced.
   assign grant_wrap = (grant_idx == TAGW'(NREQ-1)) ? '0 : grant_idx + TAGW'(1);

`ifdef FIFO2_ARB_LOCK_EN
   assign lk_wrap = (lk_idx_q == TAGW'(NREQ-1)) ? '0 : lk_idx_q + TAGW'(1);

   always_comb begin
      ptr_d    = ptr_q;
      lock_d   = lock_q;
      lk_idx_d = lk_idx_q;
      if (clear) begin
         ptr_d    = '0;
         lock_d   = 1'b0;
         lk_idx_d = '0;
      end else if (accept) begin
         if (lock_q) begin
            if (grant_last) begin
               lock_d = 1'b0;
               ptr_d  = lk_wrap;
            end
         end else begin
            ptr_d = grant_wrap;
            if (!grant_last) begin
               lock_d   = 1'b1;
               lk_idx_d = grant_idx;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q    <= '0;
         lock_q   <= 1'b0;
         lk_idx_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         lock_q   <= lock_d;
         lk_idx_q <= lk_idx_d;
      end
   end

   assign bus.BUSY = lock_q;
`else
   logic unused_last;
   assign unused_last = ^{bus.REQ_LAST, grant_last};

   always_comb begin
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = '0;
      end else if (accept) begin
         ptr_d = grant_wrap;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign bus.BUSY = 1'b0;
`endif

   assign bus.REQ_ACK = req_ack;
   assign bus.F_ENQ   = accept;
   assign bus.F_D     = {grant_idx, grant_data};

endmodule

// File: tb/tb_fifo2_rr_enq_arbiter.sv
// Scoreboard bench for fifo2_rr_enq_arbiter: a round-robin reference model predicts each enqueue,
// a negedge monitor pops and compares whenever the DUT enqueues. Lock tests need FIFO2_ARB_LOCK_EN.
module tb_fifo2_rr_enq_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int TAGW  = 2;

   typedef struct packed {
      logic [TAGW+WIDTH-1:0] fd;
      logic [NREQ-1:0]       ack;
   } exp_t;

   logic CLK;
   logic RST;
   logic CLR;

   fifo2_rr_enq_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .TAGW(TAGW)) bus ();

   fifo2_rr_enq_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TAGW(TAGW)) dut (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .bus (bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;
   exp_t exp_q[$];
   logic exp_busy = 1'b0;

   // Reference model: next-priority index, packet-lock flag and owner.
   int m_ptr  = 0;
   int m_lock = 0;
   int m_lk   = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pickWinner(input logic [NREQ-1:0] v);
      if (m_lock != 0) return v[m_lk] ? m_lk : -1;
      for (int k = 0; k < NREQ; k++) begin
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // One cycle: drive inputs after the edge, predict the response, advance the model.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d,
                                input logic [NREQ-1:0] last, input logic full_n,
                                input logic rst, input logic clr);
      int   g;
      exp_t e;
      logic [NREQ*WIDTH-1:0] sh;
      @(posedge CLK);
      #1;
      RST          = rst;
      CLR          = clr;
      bus.REQ_V    = v;
      bus.REQ_D    = d;
      bus.REQ_LAST = last;
      bus.F_FULL_N = full_n;
`ifdef FIFO2_ARB_LOCK_EN
      exp_busy = (m_lock != 0);
`else
      exp_busy = 1'b0;
`endif
      if (rst || clr) begin
         m_ptr  = 0;
         m_lock = 0;
         m_lk   = 0;
      end else begin
         g = pickWinner(v);
         if (g >= 0 && full_n) begin
            sh    = d >> (g * WIDTH);
            e.fd  = {TAGW'(g), sh[WIDTH-1:0]};
            e.ack = NREQ'(1) << g;
            exp_q.push_back(e);
`ifdef FIFO2_ARB_LOCK_EN
            if (m_lock != 0) begin
               if (last[g]) begin
                  m_lock = 0;
                  m_ptr  = (m_lk + 1) % NREQ;
               end
            end else begin
               m_ptr = (g + 1) % NREQ;
               if (!last[g]) begin
                  m_lock = 1;
                  m_lk   = g;
               end
            end
`else
            m_ptr = (g + 1) % NREQ;
`endif
         end
      end
   endtask

   // Monitor: every enqueue must match the oldest prediction; a prediction left unconsumed is a miss.
   always @(negedge CLK) begin
      exp_t e;
      if (mon_on) begin
         checkOutput("busy", 32'(bus.BUSY), 32'(exp_busy));
         if (bus.F_ENQ === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_enq actual=F_ENQ=1 expected=F_ENQ=0 at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               checkOutput("f_d", 32'(bus.F_D), 32'(e.fd));
               checkOutput("req_ack", 32'(bus.REQ_ACK), 32'(e.ack));
            end
         end else begin
            checkOutput("ack_idle", 32'(bus.REQ_ACK), 32'(0));
         end
         if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_enq actual=F_ENQ=%0b expected=F_ENQ=1 at %0t", bus.F_ENQ, $time);
            exp_q.delete();
         end
      end
   end

   initial begin
      logic [NREQ*WIDTH-1:0] rd;
      RST          = 1'b1;
      CLR          = 1'b0;
      bus.REQ_V    = '0;
      bus.REQ_D    = '0;
      bus.REQ_LAST = '1;
      bus.F_FULL_N = 1'b1;

      // Reset while everyone requests: no handshake allowed.
      applyStimulus(4'b1111, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b0);
      mon_on = 1'b1;
      applyStimulus(4'b1111, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b0);

      $display("[TB] all requesters streaming");
      for (int i = 0; i < 8; i++) applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);

      $display("[TB] backpressure then single requester 2");
      for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 32'h00A50000, 4'hF, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 32'h00A50000, 4'hF, 1'b1, 1'b0, 1'b0);

      $display("[TB] pointer wrap");
      applyStimulus(4'b0001, 32'h0000005A, 4'hF, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1001, 32'hC3000011, 4'hF, 1'b1, 1'b0, 1'b0);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 3; i++) applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b0, 1'b1);
      applyStimulus(4'b1111, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);

`ifdef FIFO2_ARB_LOCK_EN
      $display("[TB] packet lock on requester 1");
      applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0001, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0111, 32'h00A1B1C1, 4'b0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0111, 32'h00A2B2C2, 4'b0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0111, 32'h00A3B3C3, 4'b0010, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0101, 32'h00A4B4C4, 4'hF, 1'b1, 1'b0, 1'b0);

      $display("[TB] clear while locked on requester 3");
      applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b1000, 32'h77000000, 4'b0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1111, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b1);
      applyStimulus(4'b1111, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0);
`endif

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         rd = $urandom;
         applyStimulus(NREQ'($urandom), rd, NREQ'($urandom | $urandom), ($urandom_range(3, 0) != 0),
                       ($urandom_range(99, 0) == 0), ($urandom_range(49, 0) == 0));
      end

      applyStimulus(4'b0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      #1;
      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
